adder_rr_sched: RTL and testbench
=================================

// Module: adder_rr_sched
// PURPOSE
//  Shares one W-bit adder between two requesters using round-robin arbitration
//  and valid/ready handshakes. Each requester owns a running accumulator
//  usable as operand A.
//  Sits between the pin-level input decode and the uo_out path of the top
//  wrapper, replacing the free-running combinational sum.
// PARAMETERS
//  W  8  operand/result width in bits
// PORTS
//  clk         in   1  clock, rising edge
//  rst_n       in   1  reset; asynchronous and active-low
//  req0_valid  in   1  requester 0 has an operation pending
//  req0_a      in   W  requester 0 operand A (ignored when req0_acc=1)
//  req0_b      in   W  requester 0 operand B
//  req0_acc    in   1  1: A := accumulator 0
//  req0_ready  out  1  requester 0 operation accepted this cycle (valid&ready)
//  req1_*      -    -  identical set for requester 1
//  res_valid   out  1  result slot holds a result
//  res_data    out  W  sum, low W bits
//  res_carry   out  1  carry-out of the sum
//  res_id      out  1  requester index that produced the result
//  res_ready   in   1  consumer takes the result when res_valid&res_ready
//  busy        out  1  res_valid | req0_valid | req1_valid
// BEHAVIOUR
//  - Reset values: res_valid=0, res_data=0, res_carry=0, res_id=0,
//    both acc=0, last_grant=1 (so requester 0 wins first).
//  - slot_free = !res_valid | res_ready.
//  - Grant (combinational), only when slot_free:
//    - One valid requester: it wins.
//    - Both valid: the one != last_grant wins.
//    - reqN_ready = slot_free & grantN. Never both high. Ready does not depend
//      on the requester's own valid, except through the grant.
//  - Accept (valid&ready) on edge k:
//    - {res_carry,res_data} <= A + B, computed at W+1 bits.
//    - res_id <= winner; res_valid <= 1.
//    - acc[winner] <= sum[W-1:0], on every accept, whether or not acc was
//      selected.
//    - last_grant <= winner.
//    - Latency: 1 cycle; result is visible from edge k.
//  - No accept while slot is occupied and not drained:
//    - res_valid <= res_valid & !res_ready.
//    - res_* hold stable while res_valid & !res_ready.
//  - Simultaneous drain+accept: the slot is refilled in the same edge, giving
//    1 op/cycle sustained throughput.
//  - Wrap-around: the sum truncates mod 2^W and carry reports overflow.
//    Example: acc=0xFF, B=0x01 -> data 0x00, carry 1, acc 0x00.
//  - last_grant only changes on accept; an idle cycle does not rotate priority.
//  - Requester dropping valid without acceptance is legal; it loses nothing.
//    Operands are sampled only at accept.
//  - Reset mid-operation: asynchronous clear to the reset values above. A
//    pending result is discarded and accumulators are cleared.
//  - States: EMPTY (res_valid=0), FULL (res_valid=1).
//    - EMPTY -> FULL on accept.
//    - FULL -> EMPTY on res_ready without accept.
//    - FULL -> FULL otherwise.
// STRUCTURE
//  - Shared package adder_sched_pkg: default W; state enum {EMPTY, FULL};
//    requester-id type (1 bit); reset constants (LAST_GRANT_RST=1).
//  - One sub-module rr_arb2: inputs valid[1:0], last_grant, en -> grant[1:0]
//    one-hot/zero. Purely combinational, reusable for later shared
//    resources.
//  - Top holds the adder, result slot, accumulators and last_grant registers.
// TESTING
//  1. Reset: hold rst_n=0 mid-run with res_valid=1 -> all outputs 0
//     immediately (async); first accept after release goes to req0 when
//     both valid.
//  2. Single op: req0 a=0x12 b=0x34, res_ready=1 -> next cycle res_valid=1,
//     data=0x46, carry=0, id=0.
//  3. Contention: both valid every cycle, res_ready=1 -> ids alternate
//     0,1,0,1; one result per cycle.
//  4. Backpressure: res_ready=0 for 3 cycles with a result held -> res_*
//     stable, both ready=0. Then res_ready=1 -> drain and refill in the same
//     cycle.
//  5. Accumulate wrap: req1 acc=1, b=0x80 twice from acc 0x00 -> results
//     0x80/c0, then 0x00/c1; acc1=0x00; acc0 untouched.
//  6. Idle fairness: req1 wins, then 2 idle cycles, then both valid ->
//     req0 wins (last_grant not rotated while idle).

Source files
------------

// File: rtl/adder_sched_pkg.sv
// Shared types and constants for the round-robin adder scheduler and its
// arbiter.
package adder_sched_pkg;

    localparam int unsigned W_DEF = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    typedef logic req_id_t;

    // last_grant resets to 1 so requester 0 wins the first contended accept
    localparam req_id_t LAST_GRANT_RST = 1'b1;

endpackage

// File: rtl/adder_rr_sched_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, or zero when disabled or when
// nothing is requesting.
module rr_arb2
    import adder_sched_pkg::*;
(
    input  logic [1:0] i_valid,
    input  req_id_t    i_last_grant,
    input  logic       i_en,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = '0;
        if (i_en) begin
            unique case (i_valid)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
                default: o_grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/adder_rr_sched.sv
// One W-bit adder shared by two requesters through a single result slot,
// with per-requester accumulators and round-robin priority.
module adder_rr_sched
    import adder_sched_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_acc,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_acc,
    output logic         req1_ready,
    output logic         res_valid,
    output logic [W-1:0] res_data,
    output logic         res_carry,
    output logic         res_id,
    input  logic         res_ready,
    output logic         busy
);

    slot_state_e  r_state;
    slot_state_e  w_state_nxt;
    logic [W-1:0] r_data;
    logic         r_carry;
    req_id_t      r_id;
    req_id_t      r_last_grant;
    logic [W-1:0] r_acc [2];

    logic         w_slot_free;
    logic [1:0]   w_grant;
    logic         w_accept;
    req_id_t      w_win;
    logic [W-1:0] w_opa;
    logic [W-1:0] w_opb;
    logic         w_use_acc;
    logic [W:0]   w_sum;

    assign w_slot_free = (r_state == EMPTY) | res_ready;

    rr_arb2 u_arb (
        .i_valid      ({req1_valid, req0_valid}),
        .i_last_grant (r_last_grant),
        .i_en         (w_slot_free),
        .o_grant      (w_grant)
    );

    assign w_accept   = |w_grant;
    assign w_win      = w_grant[1];
    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    always_comb begin
        w_use_acc = w_win ? req1_acc : req0_acc;
        w_opb     = w_win ? req1_b   : req0_b;
        w_opa     = w_win ? req1_a   : req0_a;
        if (w_use_acc) begin
            w_opa = r_acc[w_win];
        end
        w_sum = {1'b0, w_opa} + {1'b0, w_opb};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            EMPTY:   if (w_accept) w_state_nxt = FULL;
            FULL:    if (res_ready && !w_accept) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        res_valid = (r_state == FULL);
        busy      = res_valid | req0_valid | req1_valid;
    end

    // Accumulator of the winner tracks every accepted sum, selected or not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data       <= '0;
            r_carry      <= 1'b0;
            r_id         <= 1'b0;
            r_last_grant <= LAST_GRANT_RST;
            for (int unsigned i = 0; i < 2; i++) begin
                r_acc[i] <= '0;
            end
        end else if (w_accept) begin
            r_data       <= w_sum[W-1:0];
            r_carry      <= w_sum[W];
            r_id         <= w_win;
            r_last_grant <= w_win;
            r_acc[w_win] <= w_sum[W-1:0];
        end
    end

    assign res_data  = r_data;
    assign res_carry = r_carry;
    assign res_id    = r_id;

endmodule

// File: tb/tb_adder_rr_sched.sv
// Directed bench for adder_rr_sched: a spec-level model checked every cycle
// plus hand-computed expectations for each scenario.
module tb_adder_rr_sched;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req0_acc, req0_ready;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_acc, req1_ready;
    logic [7:0] req1_a, req1_b;
    logic       res_valid, res_carry, res_id, res_ready, busy;
    logic [7:0] res_data;

    int n_checks = 0;
    int n_fail   = 0;

    adder_rr_sched #(.W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_acc   (req0_acc),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_acc   (req1_acc),
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_carry  (res_carry),
        .res_id     (res_id),
        .res_ready  (res_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: slot contents, accumulators and who won last
    int m_valid, m_data, m_carry, m_id, m_last;
    int m_acc [2];

    function automatic int exp_winner();
        if (m_valid != 0 && !res_ready) return -1;
        if (req0_valid && req1_valid) return (m_last == 1) ? 0 : 1;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    function automatic int exp_sum(input int w);
        int a, b;
        if (w == 0) begin
            a = req0_acc ? m_acc[0] : int'(req0_a);
            b = int'(req0_b);
        end else begin
            a = req1_acc ? m_acc[1] : int'(req1_a);
            b = int'(req1_b);
        end
        return a + b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 0; m_data <= 0; m_carry <= 0; m_id <= 0; m_last <= 1;
            m_acc[0] <= 0; m_acc[1] <= 0;
        end else if (exp_winner() >= 0) begin
            m_valid <= 1;
            m_data  <= exp_sum(exp_winner()) % 256;
            m_carry <= exp_sum(exp_winner()) / 256;
            m_id    <= exp_winner();
            m_last  <= exp_winner();
            m_acc[exp_winner()] <= exp_sum(exp_winner()) % 256;
        end else if (res_ready) begin
            m_valid <= 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("mdl_res_valid", res_valid, m_valid);
            if (m_valid != 0) begin
                check("mdl_res_data", res_data, m_data);
                check("mdl_res_carry", res_carry, m_carry);
                check("mdl_res_id", res_id, m_id);
            end
            check("mdl_req0_ready", req0_ready, exp_winner() == 0);
            check("mdl_req1_ready", req1_ready, exp_winner() == 1);
            check("mdl_busy", busy, (m_valid != 0) || req0_valid || req1_valid);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [7:0] a, input logic [7:0] b, input logic acc);
        req0_valid = v; req0_a = a; req0_b = b; req0_acc = acc;
    endtask

    task automatic set1(input logic v, input logic [7:0] a, input logic [7:0] b, input logic acc);
        req1_valid = v; req1_a = a; req1_b = b; req1_acc = acc;
    endtask

    task automatic check_res(input string name, input logic [7:0] d, input logic c, input logic id);
        check({name, "_valid"}, res_valid, 1);
        check({name, "_data"}, res_data, d);
        check({name, "_carry"}, res_carry, c);
        check({name, "_id"}, res_id, id);
    endtask

    initial begin
        rst_n = 1'b0;
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        res_ready = 1'b0;
        #2;
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_id", res_id, 0);
        tick();
        rst_n = 1'b1;

        // Single op from requester 0
        set0(1, 8'h12, 8'h34, 0);
        res_ready = 1'b1;
        #1;
        check("single_ready0", req0_ready, 1);
        tick();
        check_res("single", 8'h46, 0, 0);

        // Contention: last winner was 0, so 1,0,1,0
        set0(1, 8'h01, 8'h01, 0);
        set1(1, 8'h02, 8'h02, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_res("contend", (i % 2 == 0) ? 8'h04 : 8'h02, 0, (i % 2 == 0) ? 1'b1 : 1'b0);
        end

        // Backpressure: result held, no grants
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready0", req0_ready, 0);
            check("bp_ready1", req1_ready, 0);
            tick();
            check_res("bp_hold", 8'h02, 0, 0);
        end
        res_ready = 1'b1;
        #1;
        check("refill_ready1", req1_ready, 1);
        tick();
        check_res("refill", 8'h04, 0, 1);
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        tick();
        check("drain_valid", res_valid, 0);

        // Accumulator wrap on requester 1
        set1(1, 8'h00, 8'h00, 0);
        tick();
        set1(1, 8'h00, 8'h80, 1);
        tick();
        check_res("wrap1", 8'h80, 0, 1);
        tick();
        check_res("wrap2", 8'h00, 1, 1);
        set1(0, 0, 0, 0);
        set0(1, 8'hAA, 8'h00, 1);
        tick();
        check_res("acc0_kept", 8'h02, 0, 0);
        set0(0, 0, 0, 0);

        // Idle cycles must not rotate priority
        set1(1, 8'h00, 8'h03, 0);
        tick();
        check_res("idle_r1", 8'h03, 0, 1);
        set1(0, 0, 0, 0);
        tick();
        tick();
        check("idle_empty", res_valid, 0);
        set0(1, 8'h01, 8'h01, 0);
        set1(1, 8'h05, 8'h05, 0);
        #1;
        check("fair_ready0", req0_ready, 1);
        check("fair_ready1", req1_ready, 0);
        tick();
        check_res("fair", 8'h02, 0, 0);

        // Asynchronous reset with a held result
        res_ready = 1'b0;
        set1(0, 0, 0, 0);
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_res_valid", res_valid, 0);
        check("arst_res_data", res_data, 0);
        check("arst_res_carry", res_carry, 0);
        check("arst_res_id", res_id, 0);
        tick();
        rst_n = 1'b1;
        res_ready = 1'b1;
        set0(1, 8'hFF, 8'h05, 1);
        set1(1, 8'h07, 8'h07, 0);
        #1;
        check("post_rst_ready0", req0_ready, 1);
        tick();
        check_res("post_rst_acc0", 8'h05, 0, 0);
        set0(0, 0, 0, 0);
        tick();
        check_res("post_rst_r1", 8'h0E, 0, 1);
        set1(0, 0, 0, 0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
